// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle for the multi-cycle RV32I-subset core.
// The controller samples the latched instruction fields and ALU flags and
// drives every datapath enable and mux select. There is no valid/ready
// handshake: the controller is a pure per-cycle control source, and the
// datapath acts on whatever enables are high at each rising clock edge.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       lt;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state_dbg;

    // Controller side
    modport master (
        input  op, funct3, funct7_5, zero, lt,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal, state_dbg
    );

    // Datapath side
    modport slave (
        output op, funct3, funct7_5, zero, lt,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src,
               illegal, state_dbg
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I-subset core. One instruction takes
// 3-5 cycles: FETCH, DECODE, then a short opcode-specific tail. Illegal
// encodings are caught in DECODE and either park the FSM in HALT or are
// retired as a NOP with a one-cycle illegal pulse. All outputs are forced
// low while rst is high so no write can leak out during reset.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        ctrl
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_next;
    logic       r_illegal;
    logic       w_dec_illegal;
    logic [2:0] w_alu_funct;
    logic       w_taken;
    logic [2:0] w_imm_src;

    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;

    // State register; reset lands in FETCH so the first edge fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Illegal pulse for the NOP-retire mode: high for the cycle after DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= 1'b0;
        else     r_illegal <= (r_state == S_DECODE) && w_dec_illegal && !HALT_ON_ILLEGAL;
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        w_imm_src = 3'b000;
        case (ctrl.op)
            OP_STORE: w_imm_src = 3'b001;
            OP_BR:    w_imm_src = 3'b010;
            OP_LUI:   w_imm_src = 3'b011;
            OP_JAL:   w_imm_src = 3'b100;
            default:  w_imm_src = 3'b000;
        endcase
    end

    // ALU operation from funct3; funct7_5 only selects sub for R-type add.
    always_comb begin
        w_alu_funct = ALU_ADD;
        case (ctrl.funct3)
            3'b000:  w_alu_funct = (ctrl.op == OP_R && ctrl.funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_funct = ALU_AND;
            3'b110:  w_alu_funct = ALU_OR;
            3'b100:  w_alu_funct = ALU_XOR;
            3'b010:  w_alu_funct = ALU_SLT;
            3'b011:  w_alu_funct = ALU_SLTU;
            default: w_alu_funct = ALU_ADD;
        endcase
    end

    // Branch condition from the ALU flags of rs1 - rs2.
    always_comb begin
        w_taken = 1'b0;
        case (ctrl.funct3)
            3'b000:  w_taken = ctrl.zero;
            3'b001:  w_taken = !ctrl.zero;
            3'b100:  w_taken = ctrl.lt;
            3'b101:  w_taken = !ctrl.lt;
            default: w_taken = 1'b0;
        endcase
    end

    // Instruction decode: pick the post-DECODE state and flag bad encodings.
    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec_next    = S_FETCH;
        case (ctrl.op)
            OP_LOAD, OP_STORE: begin
                w_dec_next    = S_MEM_ADR;
                w_dec_illegal = (ctrl.funct3 != 3'b010);
            end
            OP_R: begin
                w_dec_next    = S_EXEC_R;
                w_dec_illegal = ctrl.funct7_5 ? (ctrl.funct3 != 3'b000)
                                              : (ctrl.funct3 == 3'b001 || ctrl.funct3 == 3'b101);
            end
            OP_I: begin
                w_dec_next    = S_EXEC_I;
                w_dec_illegal = (ctrl.funct3 == 3'b001 || ctrl.funct3 == 3'b101);
            end
            OP_BR: begin
                w_dec_next    = S_BRANCH;
                w_dec_illegal = (ctrl.funct3 == 3'b010 || ctrl.funct3 == 3'b011 ||
                                 ctrl.funct3 == 3'b110 || ctrl.funct3 == 3'b111);
            end
            OP_JAL:  w_dec_next = S_JAL;
            OP_JALR: begin
                w_dec_next    = S_JALR;
                w_dec_illegal = (ctrl.funct3 != 3'b000);
            end
            OP_LUI:  w_dec_next = S_LUI;
            default: w_dec_illegal = 1'b1;
        endcase
        if (w_dec_illegal) w_dec_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
    end

    // Next state and per-state control outputs; everything defaults to 0.
    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_next      = w_dec_next;
            end
            S_MEM_ADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (ctrl.op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_adr_src = 1'b1;
                w_next    = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC_R: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_alu_funct;
                w_next        = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_funct;
                w_next        = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = w_taken;
                w_next        = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALU_WB;
            end
            S_JALR: begin
                // Overwrites the PC-relative target DECODE left in ALUOut.
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = S_JAL;
            end
            S_LUI: begin
                w_result_src = 2'b11;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs are gated by rst so a mid-instruction reset kills writes at once.
    assign ctrl.pc_write    = w_pc_write  & ~rst;
    assign ctrl.adr_src     = w_adr_src   & ~rst;
    assign ctrl.mem_write   = w_mem_write & ~rst;
    assign ctrl.ir_write    = w_ir_write  & ~rst;
    assign ctrl.reg_write   = w_reg_write & ~rst;
    assign ctrl.result_src  = rst ? 2'b00 : w_result_src;
    assign ctrl.alu_src_a   = rst ? 2'b00 : w_alu_src_a;
    assign ctrl.alu_src_b   = rst ? 2'b00 : w_alu_src_b;
    assign ctrl.alu_control = rst ? 3'b000 : w_alu_control;
    assign ctrl.imm_src     = rst ? 3'b000 : w_imm_src;
    assign ctrl.illegal     = ((r_state == S_HALT) | r_illegal) & ~rst;
    assign ctrl.state_dbg   = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances share the instruction
// inputs: dut0 retires illegal encodings as NOPs, dut1 halts on them.
// Each instruction expands into the list of per-cycle control words the
// controller should show, built from the opcode table and latency rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst0;
  logic       rst1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       lt;

  int n_tests = 0;
  int n_fail  = 0;
  bit pend_ill = 1'b0;

  logic [21:0] exp_q[$];

  multicycle_controller_if if0();
  multicycle_controller_if if1();

  assign if0.op = op;       assign if1.op = op;
  assign if0.funct3 = funct3; assign if1.funct3 = funct3;
  assign if0.funct7_5 = funct7_5; assign if1.funct7_5 = funct7_5;
  assign if0.zero = zero;   assign if1.zero = zero;
  assign if0.lt = lt;       assign if1.lt = lt;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst0),
    .ctrl (if0)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst1),
    .ctrl (if1)
  );

  // clock
  always #5 clk = ~clk;

  // Control word: {pcw, adr, memw, irw, regw, res[2], a[2], b[2], alu[3], imm[3], ill, state[4]}
  function automatic logic [21:0] obs(input int sel);
    if (sel == 0)
      return {if0.pc_write, if0.adr_src, if0.mem_write, if0.ir_write, if0.reg_write,
              if0.result_src, if0.alu_src_a, if0.alu_src_b, if0.alu_control,
              if0.imm_src, if0.illegal, if0.state_dbg};
    return {if1.pc_write, if1.adr_src, if1.mem_write, if1.ir_write, if1.reg_write,
            if1.result_src, if1.alu_src_a, if1.alu_src_b, if1.alu_control,
            if1.imm_src, if1.illegal, if1.state_dbg};
  endfunction

  function automatic logic [21:0] vec(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic regw, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic [2:0] imm,
                                      input logic ill, input logic [3:0] st);
    return {pcw, adr, memw, irw, regw, res, a, b, alu, imm, ill, st};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction word into both instances and check dut 'sel'
  // cycle by cycle against the expected control-word list.
  task automatic run_word(input int sel, input logic [31:0] w, input logic z, input logic l);
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] imm;
    logic [7:0] legal_mask;
    logic [2:0] alu;
    logic       taken;
    logic       ill0;
    logic [21:0] wb;
    int         n;
    o  = w[6:0];
    f3 = w[14:12];
    f7 = w[30];
    @(negedge clk);
    op = o; funct3 = f3; funct7_5 = f7; zero = z; lt = l;

    case (o)
      7'h23:   imm = 3'd1;
      7'h63:   imm = 3'd2;
      7'h37:   imm = 3'd3;
      7'h6F:   imm = 3'd4;
      default: imm = 3'd0;
    endcase
    // bit k set = funct3 value k is a legal encoding for this opcode
    case (o)
      7'h03, 7'h23: legal_mask = 8'h04;
      7'h33:        legal_mask = f7 ? 8'h01 : 8'hDD;
      7'h13:        legal_mask = 8'hDD;
      7'h63:        legal_mask = 8'h33;
      7'h67:        legal_mask = 8'h01;
      7'h6F, 7'h37: legal_mask = 8'hFF;
      default:      legal_mask = 8'h00;
    endcase
    case (f3)
      3'b000:  alu = (o == 7'h33 && f7) ? 3'd1 : 3'd0;
      3'b111:  alu = 3'd2;
      3'b110:  alu = 3'd3;
      3'b100:  alu = 3'd4;
      3'b010:  alu = 3'd5;
      3'b011:  alu = 3'd6;
      default: alu = 3'd0;
    endcase
    taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? l : !l;
    wb = vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, imm, 0, 4'd8);

    ill0 = (sel == 0) ? pend_ill : 1'b0;
    if (sel == 0) pend_ill = 1'b0;
    exp_q.push_back(vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'd0, imm, ill0, 4'd0));
    exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, imm, 0, 4'd1));
    if (!legal_mask[f3]) begin
      if (sel == 1) repeat (12) exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, imm, 1, 4'd15));
      else pend_ill = 1'b1;
    end else begin
      case (o)
        7'h03: begin
          exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, imm, 0, 4'd2));
          exp_q.push_back(vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, imm, 0, 4'd3));
          exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'd0, imm, 0, 4'd4));
        end
        7'h23: begin
          exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, imm, 0, 4'd2));
          exp_q.push_back(vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, imm, 0, 4'd5));
        end
        7'h33: begin
          exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, imm, 0, 4'd6));
          exp_q.push_back(wb);
        end
        7'h13: begin
          exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, imm, 0, 4'd7));
          exp_q.push_back(wb);
        end
        7'h63: exp_q.push_back(vec(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, imm, 0, 4'd9));
        7'h6F: begin
          exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, imm, 0, 4'd10));
          exp_q.push_back(wb);
        end
        7'h67: begin
          exp_q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, imm, 0, 4'd11));
          exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'd0, imm, 0, 4'd10));
          exp_q.push_back(wb);
        end
        default: exp_q.push_back(vec(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'd0, imm, 0, 4'd12));
      endcase
    end

    n = 0;
    while (exp_q.size() > 0) begin
      if (n > 0) @(negedge clk);
      #1;
      check_eq($sformatf("dut%0d w=%h z=%0b lt=%0b cyc%0d", sel, w, z, l, n), 32'(obs(sel)), 32'(exp_q.pop_front()));
      n++;
    end
  endtask

  // random instruction mix: mostly real opcodes, fields random
  task automatic run_random(input int count);
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F};
    for (int i = 0; i < count; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 7)];
      else w[6:0] = 7'($urandom);
      // bias funct fields towards legal encodings
      if ($urandom_range(0, 2) != 0) w[30] = 1'b0;
      run_word(0, w, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    op = 7'h23; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset_dut0", 32'(obs(0)), 32'd0);
    check_eq("reset_dut1", 32'(obs(1)), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;

    // directed instructions on the NOP-retire instance
    run_word(0, 32'h002081B3, 0, 0);   // add x3,x1,x2
    run_word(0, 32'h402081B3, 0, 0);   // sub
    run_word(0, 32'h0000A183, 0, 0);   // lw
    run_word(0, 32'h0020A023, 0, 0);   // sw
    run_word(0, 32'h00208063, 1, 0);   // beq taken
    run_word(0, 32'h00208063, 0, 0);   // beq not taken
    run_word(0, 32'h0020D063, 0, 1);   // bge with lt=1: not taken
    run_word(0, 32'h000080E7, 0, 0);   // jalr
    run_word(0, 32'h12345037, 0, 0);   // lui
    run_word(0, 32'h008000EF, 0, 0);   // jal
    run_word(0, 32'h0000007F, 0, 0);   // illegal opcode: NOP + pulse
    run_word(0, 32'h00209033, 0, 0);   // R funct3 001 is unlisted: illegal
    run_word(0, 32'h002081B3, 0, 0);   // pulse shows in this FETCH

    run_random(150);

    // reset in the middle of lw write-back (state 4)
    run_word(0, 32'h0000A183, 0, 0);
    #1 rst0 = 1'b1;
    #1 check_eq("rst_async", 32'(obs(0)), 32'd0);
    @(negedge clk); #1;
    check_eq("rst_hold", 32'(obs(0)), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    pend_ill = 1'b0;
    run_word(0, 32'h002081B3, 0, 0);

    // halting instance: park in HALT, then recover with a reset pulse
    @(posedge clk); #1;
    rst1 = 1'b0;
    run_word(1, 32'h0000007F, 0, 0);
    #1 rst1 = 1'b1;
    #1 check_eq("halt_rst", 32'(obs(1)), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    run_word(1, 32'h12345037, 0, 0);
    run_word(1, 32'h0000A183, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
